// File: rtl/inst_fetch_axi.sv
// Instruction-fetch unit: bridges the core's ROM-style fetch port to an AXI4-Lite
// read channel through a direct-mapped instruction buffer of LINES entries.
module inst_fetch_axi #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ce_i,
  input  logic [ADDR_WIDTH-1:0] rom_addr_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] rom_data_o,
  output logic                  rom_valid_o,
  output logic                  fetch_err_o,
  output logic                  stall_o,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);
  localparam int OFF  = $clog2(DATA_WIDTH / 8);
  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = ADDR_WIDTH - OFF - IDX;

  typedef enum logic [1:0] {IDLE = 2'd0, AR = 2'd1, R = 2'd2, RESP = 2'd3} state_t;
  state_t state_r, state_s;

  logic [LINES-1:0]      valid_r;
  logic [TAGW-1:0]       tag_r  [LINES];
  logic [DATA_WIDTH-1:0] data_r [LINES];
  logic [IDX-1:0]        req_idx_r;
  logic [TAGW-1:0]       req_tag_r;
  logic                  flushed_r;
  logic                  ce_lost_r;

  logic [IDX-1:0]        idx_s;
  logic [TAGW-1:0]       tag_s;
  logic                  misalign_s, hit_s;
  logic                  accept_s, miss_s, ar_done_s, resp_load_s, resp_show_s, resp_err_s, fill_s;
  logic [DATA_WIDTH-1:0] resp_data_s;

  assign idx_s      = rom_addr_i[OFF+IDX-1:OFF];
  assign tag_s      = rom_addr_i[ADDR_WIDTH-1:OFF+IDX];
  assign misalign_s = |rom_addr_i[OFF-1:0];
  // A same-cycle flush wins over the lookup, so the fetch goes to the bus.
  assign hit_s      = valid_r[idx_s] && (tag_r[idx_s] == tag_s) && !flush_i;
  assign stall_o    = rom_ce_i & ~rom_valid_o;
  assign arprot     = 3'b100;

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_s     = state_r;
    accept_s    = 1'b0;
    miss_s      = 1'b0;
    ar_done_s   = 1'b0;
    resp_load_s = 1'b0;
    resp_show_s = 1'b0;
    resp_err_s  = 1'b0;
    fill_s      = 1'b0;
    resp_data_s = '0;
    case (state_r)
      IDLE: begin
        if (rom_ce_i) begin
          accept_s = 1'b1;
          if (misalign_s) begin
            state_s     = RESP;
            resp_load_s = 1'b1;
            resp_show_s = 1'b1;
            resp_err_s  = 1'b1;
          end else if (hit_s) begin
            state_s     = RESP;
            resp_load_s = 1'b1;
            resp_show_s = 1'b1;
            resp_data_s = data_r[idx_s];
          end else begin
            state_s = AR;
            miss_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      AR: begin
        if (arready) begin
          state_s   = R;
          ar_done_s = 1'b1;
        end else begin
          state_s = AR;
        end
      end
      R: begin
        if (rvalid) begin
          state_s     = RESP;
          resp_load_s = 1'b1;
          // A core that gave up on the fetch gets no response, but the fill still happens.
          resp_show_s = rom_ce_i & ~ce_lost_r;
          if (rresp == 2'b00) begin
            resp_data_s = rdata;
            fill_s      = ~flushed_r & ~flush_i;
          end else begin
            resp_err_s  = 1'b1;
          end
        end else begin
          state_s = R;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state, bus handshake outputs, core response and buffer valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      rom_valid_o <= 1'b0;
      rom_data_o  <= '0;
      fetch_err_o <= 1'b0;
      arvalid     <= 1'b0;
      araddr      <= '0;
      rready      <= 1'b0;
      req_idx_r   <= '0;
      req_tag_r   <= '0;
      flushed_r   <= 1'b0;
      ce_lost_r   <= 1'b0;
      valid_r     <= '0;
    end else begin
      state_r     <= state_s;
      rom_valid_o <= resp_show_s;
      fetch_err_o <= resp_show_s & resp_err_s;
      if (resp_load_s) rom_data_o <= resp_data_s;
      if (accept_s) begin
        req_idx_r <= idx_s;
        req_tag_r <= tag_s;
      end
      if (miss_s) begin
        araddr  <= rom_addr_i;
        arvalid <= 1'b1;
      end else if (ar_done_s) begin
        arvalid <= 1'b0;
      end
      if (ar_done_s) rready <= 1'b1;
      else if (resp_load_s) rready <= 1'b0;
      if (accept_s) flushed_r <= 1'b0;
      else if (flush_i) flushed_r <= 1'b1;
      if (accept_s) ce_lost_r <= 1'b0;
      else if (!rom_ce_i) ce_lost_r <= 1'b1;
      if (flush_i) valid_r <= '0;
      else if (fill_s) valid_r[req_idx_r] <= 1'b1;
    end
  end

  // Buffer payload; only meaningful where the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_r[req_idx_r]  <= req_tag_r;
      data_r[req_idx_r] <= rdata;
    end
  end
endmodule

// File: doc/inst_fetch_axi.md
# inst_fetch_axi

Parametrised instruction-fetch unit that sits between the core's ROM-style fetch port (ce/addr/data) and an AXI4-Lite read channel, replacing the direct core-to-ROM connection of the previous top level. It holds a small direct-mapped instruction buffer (`LINES` entries), so repeated fetches skip the bus. It reports bus and alignment errors to the core and stalls the core while a miss is outstanding. One AXI read is in flight at a time.

## Interface
- `ADDR_WIDTH`, 32: byte-address width of the fetch port and of `araddr`.
- `DATA_WIDTH`, 32: instruction/`rdata` width; must be 32 or 64. `OFF = log2(DATA_WIDTH/8)`.
- `LINES`, 4: buffer entries; power of two, ≥2. `IDX = log2(LINES)`; tag = `addr[ADDR_WIDTH-1:OFF+IDX]`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rom_ce_i` in 1: fetch request; held high with a stable `rom_addr_i` until `rom_valid_o`.
- `rom_addr_i` in ADDR_WIDTH: fetch byte address.
- `flush_i` in 1: invalidates all buffer entries (fence.i).
- `rom_data_o` out DATA_WIDTH: instruction; meaningful only while `rom_valid_o` is high.
- `rom_valid_o` out 1: one-cycle response pulse.
- `fetch_err_o` out 1: qualifies `rom_valid_o`; high means a bus error or misaligned fetch.
- `stall_o` out 1: combinational, equals `rom_ce_i & ~rom_valid_o`.
- `araddr` out ADDR_WIDTH, `arprot` out 3 (constant 3'b100), `arvalid` out 1, `arready` in 1: AXI read-address channel.
- `rdata` in DATA_WIDTH, `rresp` in 2, `rvalid` in 1, `rready` out 1: AXI read-data channel.

## Operation
- The FSM has four states: IDLE, AR, R, RESP.
- **IDLE, `rom_ce_i` = 1:** register `rom_addr_i` into `req_addr`, then take the first matching case:
  - Misaligned (`rom_addr_i[OFF-1:0]` ≠ 0): go to RESP with error; no bus access.
  - Buffer hit (entry `idx` valid, tag equal, `flush_i` = 0): go to RESP with the buffered data.
  - Otherwise: go to AR with `araddr` = `rom_addr_i` and `arvalid` = 1.
- **AR:** hold `arvalid`/`araddr` stable until `arready`. On handshake drop `arvalid`, set `rready` = 1 and go to R.
- **R:** on `rvalid`, drop `rready` and go to RESP.
  - `rresp` = 2'b00: capture `rdata`. Write entry `idx` (valid, tag, data) unless a flush occurred since the request was accepted.
  - `rresp` ≠ 2'b00: set the error flag. Return data 0 and leave the buffer entry unchanged.
- **RESP:** drive `rom_valid_o` = 1 for exactly one cycle with `rom_data_o`/`fetch_err_o`, then go to IDLE.
  - If `rom_ce_i` dropped during AR/R, the fill still happens but `rom_valid_o` is suppressed.
- **`flush_i`:** clears every valid bit in the same edge, in any state.
  - It has priority over a hit lookup in the same cycle (that fetch is treated as a miss).
  - It suppresses the fill of an in-flight miss. The in-flight response is still returned to the core.
- **Reset:** async clear of the FSM to IDLE, all valid bits, and all outputs.
  - Any outstanding AXI transaction is abandoned; the slave is expected to share the reset.

## Timing
- Reset values: `rom_valid_o` 0, `rom_data_o` 0, `fetch_err_o` 0, `arvalid` 0, `araddr` 0, `rready` 0. `stall_o` follows its equation.
- Request seen in IDLE at cycle 0:
  - Hit or misaligned: `rom_valid_o` at cycle 1.
  - Miss: `arvalid` from cycle 1, `rready` from the cycle after the AR handshake, `rom_valid_o` the cycle after the R handshake (minimum cycle 3).
- `stall_o` is high from cycle 0 until the `rom_valid_o` cycle, and low in that cycle.
- A new request can be accepted in the cycle after `rom_valid_o` (back-to-back hits: one instruction every 2 cycles).
- `arvalid` never drops before `arready`. `araddr` is stable while `arvalid` is high. `rready` is high only in R.
- `rdata`/`rresp` are sampled only when `rvalid & rready`.

## Test plan
- **Reset:** assert `rst` = 0 mid-R state → next edge all outputs 0, FSM in IDLE. A later fetch of the same address misses (`arvalid` seen).
- **Cold miss then hit:** fetch 0x100, slave `arready` at cycle 2 and `rvalid` at cycle 4 with `rdata` 0x00A00093 / OKAY → `rom_valid_o` at cycle 5 with data 0x00A00093. Refetching 0x100 → `rom_valid_o` 1 cycle later, no `arvalid`.
- **Conflict eviction (`LINES`=4, 32-bit):** fetch 0x100, 0x110 (same index, new tag), then 0x100 → three AXI reads issued.
- **Bus error:** fetch 0x200 with `rresp` = 2'b10 → `rom_valid_o` = 1, `fetch_err_o` = 1, `rom_data_o` = 0. Refetching 0x200 issues a new AXI read.
- **Misaligned:** fetch 0x102 → `fetch_err_o` pulse at cycle 1, `arvalid` never asserted.
- **Flush:** pulse `flush_i` during R of 0x300 → data returned. Refetching 0x300 misses, and a previously cached 0x100 also misses.
